// File: rtl/next_pc_unit.sv
// Next-PC generator closing the fetch loop: sequential advance, same-cycle JAL,
// branch/JALR redirects resolved by execute, stall hold and halt on SYSTEM.
module next_pc_unit #(
  parameter int unsigned XLEN           = 32,
  parameter bit          HALT_ON_SYSTEM = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] inst_address,
  input  logic [31:0]     inst_code,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic [XLEN-1:0] next_pc,
  output logic            fetch_bubble,
  output logic            halted,
  output logic            misalign_err
);

  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [1:0] {StSeq, StWait, StPend, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] saved_pc_q, saved_pc_d;
  logic            pend_taken_q, pend_taken_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            misalign_q, misalign_d;

  logic [6:0]      opcode;
  logic [XLEN-1:0] jal_imm;
  logic            redir;
  logic [XLEN-1:0] redir_tgt;
  logic            unused_inst;

  assign opcode      = inst_code[6:0];
  assign jal_imm     = {{(XLEN-20){inst_code[31]}}, inst_code[19:12], inst_code[20],
                        inst_code[30:21], 1'b0};
  assign unused_inst = ^inst_code[11:7];

  always_comb begin
    state_d       = state_q;
    saved_pc_d    = saved_pc_q;
    pend_taken_d  = pend_taken_q;
    pend_target_d = pend_target_q;
    misalign_d    = misalign_q;
    next_pc       = inst_address;
    redir         = 1'b0;
    redir_tgt     = '0;

    unique case (state_q)
      StSeq: begin
        if (!stall) begin
          case (opcode)
            OpJal: begin
              redir     = 1'b1;
              redir_tgt = inst_address + jal_imm;
            end
            OpBranch, OpJalr: begin
              saved_pc_d = inst_address;
              state_d    = StWait;
            end
            OpSystem: begin
              if (HALT_ON_SYSTEM) state_d = StHalt;
              else                next_pc = inst_address + XLEN'(4);
            end
            default: next_pc = inst_address + XLEN'(4);
          endcase
        end
      end
      StWait: begin
        if (ex_valid) begin
          if (stall) begin
            // Execute only presents its result for one cycle; park it until the stall lifts.
            pend_taken_d  = ex_taken;
            pend_target_d = ex_target;
            state_d       = StPend;
          end else begin
            state_d = StSeq;
            if (ex_taken) begin
              redir     = 1'b1;
              redir_tgt = ex_target;
            end else begin
              next_pc = saved_pc_q + XLEN'(4);
            end
          end
        end
      end
      StPend: begin
        if (!stall) begin
          state_d = StSeq;
          if (pend_taken_q) begin
            redir     = 1'b1;
            redir_tgt = pend_target_q;
          end else begin
            next_pc = saved_pc_q + XLEN'(4);
          end
        end
      end
      StHalt: ;
      default: state_d = StSeq;
    endcase

    // Misaligned targets are still followed, word-aligned, and flagged.
    if (redir) begin
      next_pc = {redir_tgt[XLEN-1:2], 2'b00};
      if (redir_tgt[1:0] != 2'b00) misalign_d = 1'b1;
    end

    if (!reset) begin
      state_d       = StSeq;
      saved_pc_d    = '0;
      pend_taken_d  = 1'b0;
      pend_target_d = '0;
      misalign_d    = 1'b0;
      next_pc       = '0;
    end
  end

  always_ff @(posedge clock) begin
    state_q       <= state_d;
    saved_pc_q    <= saved_pc_d;
    pend_taken_q  <= pend_taken_d;
    pend_target_q <= pend_target_d;
    misalign_q    <= misalign_d;
  end

  assign fetch_bubble = !reset || (state_q != StSeq);
  assign halted       = (state_q == StHalt);
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Scenario bench for next_pc_unit: per-cycle stimulus tables with a queue of
// expected {next_pc, fetch_bubble, halted, misalign_err} popped after each drive.
module tb_next_pc_unit;

  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [31:0] Beq     = 32'h0000_0063;
  localparam logic [31:0] Jalr    = 32'h0000_0067;
  localparam logic [31:0] Ecall   = 32'h0000_0073;
  localparam logic [31:0] JalM16  = 32'hFF1F_F06F;
  localparam logic [31:0] JalP8   = 32'h0080_006F;

  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic [31:0] code;
    logic        st;
    logic        ev;
    logic        et;
    logic [31:0] tgt;
    logic [31:0] npc;
    logic        bub;
    logic        hlt;
    logic        mis;
  } step_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inst_address;
  logic [31:0] inst_code;
  logic        stall;
  logic        ex_valid;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] next_pc;
  logic        fetch_bubble;
  logic        halted;
  logic        misalign_err;

  logic [34:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clock = ~clock;

  next_pc_unit #(
    .XLEN          (32),
    .HALT_ON_SYSTEM(1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .inst_address(inst_address),
    .inst_code   (inst_code),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_taken    (ex_taken),
    .ex_target   (ex_target),
    .next_pc     (next_pc),
    .fetch_bubble(fetch_bubble),
    .halted      (halted),
    .misalign_err(misalign_err)
  );

  task automatic drive(input step_t s);
    @(negedge clock);
    reset        = s.rst;
    inst_address = s.addr;
    inst_code    = s.code;
    stall        = s.st;
    ex_valid     = s.ev;
    ex_taken     = s.et;
    ex_target    = s.tgt;
    exp_q.push_back({s.npc, s.bub, s.hlt, s.mis});
  endtask

  task automatic test_reset();
    step_t s[$];
    logic [34:0] e;
    s.push_back('{1'b0, 32'hFFFF_FFFC, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b0, 32'hFFFF_FFFC, Nop, 1'b0, 1'b1, 1'b1, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'hFFFF_FFFC, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h0000_0000, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h0000_0004, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8, 1'b0, 1'b0, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      #1;
      e = exp_q.pop_front();
      total++;
      if ({next_pc, fetch_bubble, halted, misalign_err} !== e) begin
        bad++;
        $display("FAIL reset[%0d] got npc=%h bub=%b hlt=%b mis=%b want npc=%h bub=%b hlt=%b mis=%b",
                 i, next_pc, fetch_bubble, halted, misalign_err, e[34:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_seq_jal();
    step_t s[$];
    logic [34:0] e;
    s.push_back('{1'b1, 32'h0000_0010, JalM16, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'hFFFF_FFFC, JalP8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'hFFFF_FFFC, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    // Stalled branch must not be decoded: the following cycle stays sequential.
    s.push_back('{1'b1, 32'h0000_0008, Beq, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8, 1'b0, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h0000_0008, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'hC, 1'b0, 1'b0, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      #1;
      e = exp_q.pop_front();
      total++;
      if ({next_pc, fetch_bubble, halted, misalign_err} !== e) begin
        bad++;
        $display("FAIL seq_jal[%0d] got npc=%h bub=%b hlt=%b mis=%b want npc=%h bub=%b hlt=%b mis=%b",
                 i, next_pc, fetch_bubble, halted, misalign_err, e[34:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_branch();
    step_t s[$];
    logic [34:0] e;
    s.push_back('{1'b1, 32'h20, Beq, 1'b0, 1'b0, 1'b0, 32'h0, 32'h20, 1'b0, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h20, JalM16, 1'b0, 1'b0, 1'b0, 32'h0, 32'h20, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h20, JalM16, 1'b0, 1'b1, 1'b0, 32'h100, 32'h24, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h24, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h28, 1'b0, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h20, Beq, 1'b0, 1'b0, 1'b0, 32'h0, 32'h20, 1'b0, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h20, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h20, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h20, Nop, 1'b0, 1'b1, 1'b1, 32'h100, 32'h100, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h100, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h104, 1'b0, 1'b0, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      #1;
      e = exp_q.pop_front();
      total++;
      if ({next_pc, fetch_bubble, halted, misalign_err} !== e) begin
        bad++;
        $display("FAIL branch[%0d] got npc=%h bub=%b hlt=%b mis=%b want npc=%h bub=%b hlt=%b mis=%b",
                 i, next_pc, fetch_bubble, halted, misalign_err, e[34:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_pend();
    step_t s[$];
    logic [34:0] e;
    s.push_back('{1'b1, 32'h40, Jalr, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h40, Nop, 1'b1, 1'b1, 1'b1, 32'h202, 32'h40, 1'b1, 1'b0, 1'b0});
    // Late ex_valid in PEND with a different result must be ignored.
    s.push_back('{1'b1, 32'h40, Nop, 1'b1, 1'b1, 1'b0, 32'h300, 32'h40, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h40, Nop, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h40, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h200, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h200, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h204, 1'b0, 1'b0, 1'b1});
    s.push_back('{1'b1, 32'h50, Beq, 1'b0, 1'b0, 1'b0, 32'h0, 32'h50, 1'b0, 1'b0, 1'b1});
    s.push_back('{1'b1, 32'h50, Nop, 1'b1, 1'b1, 1'b0, 32'h998, 32'h50, 1'b1, 1'b0, 1'b1});
    s.push_back('{1'b1, 32'h50, Nop, 1'b0, 1'b0, 1'b1, 32'h998, 32'h54, 1'b1, 1'b0, 1'b1});
    s.push_back('{1'b1, 32'h54, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h58, 1'b0, 1'b0, 1'b1});
    foreach (s[i]) begin
      drive(s[i]);
      #1;
      e = exp_q.pop_front();
      total++;
      if ({next_pc, fetch_bubble, halted, misalign_err} !== e) begin
        bad++;
        $display("FAIL pend[%0d] got npc=%h bub=%b hlt=%b mis=%b want npc=%h bub=%b hlt=%b mis=%b",
                 i, next_pc, fetch_bubble, halted, misalign_err, e[34:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_halt();
    step_t s[$];
    logic [34:0] e;
    s.push_back('{1'b1, 32'h30, Ecall, 1'b0, 1'b0, 1'b0, 32'h0, 32'h30, 1'b0, 1'b0, 1'b1});
    for (int k = 0; k < 10; k++) begin
      s.push_back('{1'b1, 32'h30, Nop, k[1], k[0], 1'b1, 32'h100, 32'h30, 1'b1, 1'b1, 1'b1});
    end
    s.push_back('{1'b0, 32'h30, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1});
    s.push_back('{1'b0, 32'h30, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'hFFFF_FFFC, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      #1;
      e = exp_q.pop_front();
      total++;
      if ({next_pc, fetch_bubble, halted, misalign_err} !== e) begin
        bad++;
        $display("FAIL halt[%0d] got npc=%h bub=%b hlt=%b mis=%b want npc=%h bub=%b hlt=%b mis=%b",
                 i, next_pc, fetch_bubble, halted, misalign_err, e[34:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    step_t s[$];
    logic [34:0] e;
    s.push_back('{1'b1, 32'h0, Beq, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h0, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b0, 32'h0, Nop, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b0, 32'h0, Nop, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 1'b1, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'hFFFF_FFFC, Nop, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0});
    s.push_back('{1'b1, 32'h0, Nop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      #1;
      e = exp_q.pop_front();
      total++;
      if ({next_pc, fetch_bubble, halted, misalign_err} !== e) begin
        bad++;
        $display("FAIL rst_wait[%0d] got npc=%h bub=%b hlt=%b mis=%b want npc=%h bub=%b hlt=%b mis=%b",
                 i, next_pc, fetch_bubble, halted, misalign_err, e[34:3], e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    reset        = 1'b0;
    inst_address = 32'hFFFF_FFFC;
    inst_code    = Nop;
    stall        = 1'b0;
    ex_valid     = 1'b0;
    ex_taken     = 1'b0;
    ex_target    = 32'h0;
    repeat (2) @(posedge clock);
    test_reset();
    test_seq_jal();
    test_branch();
    test_pend();
    test_halt();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Produces the next_pc value that the PC register loads on every rising clock edge.
- Closes the fetch loop: takes the current inst_address and the fetched inst_code, and returns the address to fetch next.
- Handles sequential advance, JAL in the same cycle, and branch/JALR redirects resolved by execute through an ex_valid handshake.
- Also handles pipeline stalls and a halt on SYSTEM instructions.

Parameters:
- XLEN, 32: address/data width. All adds are modulo 2^XLEN.
- HALT_ON_SYSTEM, 1: when 1, opcode 1110011 (ECALL/EBREAK) enters HALT. When 0, it is treated as sequential.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- inst_address  in  XLEN  current PC (address of inst_code)
- inst_code  in  32  instruction fetched at inst_address
- stall  in  1  downstream stall; PC must hold
- ex_valid  in  1  execute presents a branch/JALR resolution this cycle
- ex_taken  in  1  resolution: 1 = taken
- ex_target  in  XLEN  taken target (branch target or JALR rs1+imm)
- next_pc  out  XLEN  address the PC register loads at the next edge (combinational from inputs and state)
- fetch_bubble  out  1  current inst_code is invalid/ignored (registered-state driven)
- halted  out  1  core halted (registered)
- misalign_err  out  1  sticky: a redirect target had bits[1:0] != 00 (registered)

Behaviour:
- Reset: reset==0 at an edge forces state=SEQ, saved_pc=0, pend_taken=0, pend_target=0, halted=0, misalign_err=0. While reset==0, next_pc=0 and fetch_bubble=1. Reset overrides every other input, including mid-WAIT and in HALT.
- After reset releases, the PC register holds 0xFFFFFFFC, so SEQ yields next_pc=0x00000000 (first fetch at 0).
- States: SEQ, WAIT, PEND, HALT.
- SEQ, decode active, fetch_bubble=0:
  - stall=1: next_pc=inst_address; no state change; no decode side effects.
  - opcode 1101111 (JAL): next_pc = inst_address + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}). Zero-cycle redirect, state stays SEQ.
  - opcode 1100011 (BRANCH) or 1100111 (JALR): saved_pc <= inst_address; next_pc=inst_address (hold); go to WAIT.
  - opcode 1110011 with HALT_ON_SYSTEM=1: next_pc=inst_address; go to HALT.
  - Otherwise: next_pc = inst_address + 4.
- WAIT, fetch_bubble=1, inst_code ignored:
  - ex_valid=0: next_pc=inst_address; stay.
  - ex_valid=1, stall=0: next_pc = ex_taken ? ex_target : saved_pc+4; go to SEQ.
  - ex_valid=1, stall=1: capture pend_taken<=ex_taken and pend_target<=ex_target; next_pc=inst_address; go to PEND.
- PEND, fetch_bubble=1, ex_valid ignored:
  - stall=1: next_pc=inst_address; stay.
  - stall=0: next_pc = pend_taken ? pend_target : saved_pc+4; go to SEQ.
- HALT: next_pc=inst_address, halted=1, fetch_bubble=1. Exit only by reset.
- Misalignment: any taken redirect (JAL, ex_target, or pend_target) with target[1:0]!=00 drives next_pc with bits[1:0] forced to 00 and sets misalign_err (sticky until reset).
- Wrap-around: 0xFFFFFFFC+4 = 0x00000000. Negative offsets wrap modulo 2^32. No error flagged.
- Latency: sequential and JAL = 0 cycles (next edge). Branch/JALR = 1 bubble minimum, plus the wait until ex_valid, plus stall cycles.
- ex_valid asserted in SEQ or HALT is ignored. Execute must assert it only while fetch_bubble=1 and the state is WAIT.

Test Plan:
- Reset low 2 cycles, then release with ADDI stream: PC sequence FFFFFFFC -> 0 -> 4 -> 8; next_pc=0 during reset; fetch_bubble=0 after release.
- JAL at 0x10 with offset -16 (inst 0xFF1FF06F): next_pc=0x00000000 in the same cycle, no bubble. JAL at 0xFFFFFFFC with +8: next_pc=0x00000004 (wrap).
- BEQ at 0x20, ex_valid=1 two cycles later with ex_taken=0: PC holds 0x20 for 2 edges with fetch_bubble=1, then next_pc=0x24. Repeat with ex_taken=1, ex_target=0x100: next_pc=0x100.
- JALR at 0x40, ex_valid=1 with stall=1 and ex_target=0x202 (taken), stall held 3 cycles: state PEND, PC holds 0x40, ex_valid dropped. On stall release: next_pc=0x200 and misalign_err=1 (stays 1).
- ECALL (0x00000073) at 0x30: halted=1, PC frozen at 0x30 for 10 cycles regardless of ex_valid. reset=0 returns all outputs to reset values and clears misalign_err.
- Reset asserted while in WAIT: state returns to SEQ. After release, fetch restarts at 0 with no stale redirect applied.
